// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, default widths
// and the sequential PC step.
package fetch_pkg;

    localparam int unsigned PC_W_DEFAULT   = 16;
    localparam int unsigned INST_W_DEFAULT = 16;
    localparam int unsigned OFFS_W_DEFAULT = 10;

    // Instructions are 16-bit, so the PC advances in bytes by two.
    localparam int unsigned PC_STEP = 2;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_FETCH = 2'd1;
    localparam state_t S_HOLD  = 2'd2;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Memory and control-unit signals of the fetch unit. The fetch unit takes the
// master view; the memory/control-unit side takes the slave view.
interface instr_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEFAULT,
    parameter int unsigned INST_W = INST_W_DEFAULT,
    parameter int unsigned OFFS_W = OFFS_W_DEFAULT
);

    logic              mem_req;
    logic [PC_W-1:0]   mem_addr;
    logic              mem_ack;
    logic [INST_W-1:0] mem_rdata;
    logic [INST_W-1:0] instruction;
    logic              inst_valid;
    logic              inst_load;
    logic [PC_W-1:0]   pc;
    logic              pc_inc;
    logic              en_pc_2;
    logic              branch_en;
    logic [OFFS_W-1:0] pc_offset;

    modport master (
        output mem_req, mem_addr, instruction, inst_valid, inst_load, pc,
        input  mem_ack, mem_rdata, pc_inc, en_pc_2, branch_en, pc_offset
    );

    modport slave (
        input  mem_req, mem_addr, instruction, inst_valid, inst_load, pc,
        output mem_ack, mem_rdata, pc_inc, en_pc_2, branch_en, pc_offset
    );

endinterface

// File: rtl/instr_fetch_unit_pc_next_gen.sv
// Combinational next-PC selection: branch target, sequential step, or hold.
module pc_next_gen
    import fetch_pkg::*;
#(
    parameter int unsigned PC_W   = PC_W_DEFAULT,
    parameter int unsigned OFFS_W = OFFS_W_DEFAULT
) (
    input  logic [PC_W-1:0]   pc_i,
    input  logic              en_pc_2_i,
    input  logic              branch_en_i,
    input  logic [OFFS_W-1:0] pc_offset_i,
    output logic [PC_W-1:0]   next_pc_o
);

    logic signed [PC_W-1:0] offs_sx;
    logic [PC_W-1:0]        byte_offs;
    logic [PC_W-1:0]        seq_pc;
    logic [PC_W-1:0]        sel_pc;

    // Word offset, sign-extended then scaled to bytes; all sums wrap mod 2^PC_W.
    assign offs_sx   = PC_W'($signed(pc_offset_i));
    assign byte_offs = {offs_sx[PC_W-2:0], 1'b0};
    assign seq_pc    = pc_i + PC_W'(PC_STEP);

    always_comb begin
        sel_pc = pc_i;
        if (branch_en_i) begin
            sel_pc = seq_pc + byte_offs;
        end else if (en_pc_2_i) begin
            sel_pc = seq_pc;
        end
        next_pc_o = {sel_pc[PC_W-1:1], 1'b0};
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter owner: fetches one instruction per req/ack transaction, holds it
// for the control unit and applies its PC command to form the next fetch address.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     PC_W         = PC_W_DEFAULT,
    parameter int unsigned     INST_W       = INST_W_DEFAULT,
    parameter int unsigned     OFFS_W       = OFFS_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_unit_if.master bus_io
);

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] instr_q, instr_d;
    logic              load_q, load_d;
    logic [PC_W-1:0]   next_pc;

    pc_next_gen #(
        .PC_W   (PC_W),
        .OFFS_W (OFFS_W)
    ) u_pc_next_gen (
        .pc_i        (pc_q),
        .en_pc_2_i   (bus_io.en_pc_2),
        .branch_en_i (bus_io.branch_en),
        .pc_offset_i (bus_io.pc_offset),
        .next_pc_o   (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        load_d  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (bus_io.mem_ack) begin
                    instr_d = bus_io.mem_rdata;
                    load_d  = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // No command: instruction stays visible until the control unit acts.
                if (bus_io.pc_inc) begin
                    pc_d    = next_pc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= {RESET_VECTOR[PC_W-1:1], 1'b0};
            instr_q <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            load_q  <= load_d;
        end
    end

    assign bus_io.mem_req     = (state_q == S_FETCH);
    assign bus_io.mem_addr    = pc_q;
    assign bus_io.pc          = pc_q;
    assign bus_io.instruction = instr_q;
    assign bus_io.inst_valid  = (state_q == S_HOLD);
    assign bus_io.inst_load   = load_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a scripted memory responder and control unit
// drive the interface, and every observation is checked with an immediate assertion.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_W(16), .INST_W(16), .OFFS_W(10)) bus ();

    instr_fetch_unit #(
        .PC_W         (16),
        .INST_W       (16),
        .OFFS_W       (10),
        .RESET_VECTOR (16'h0000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bus.mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " mem_req rise"}, 32'(bus.mem_req), 32'd1);
    endtask

    // Answer the pending fetch after `delay` extra wait cycles.
    task automatic serve(input string tag, input logic [15:0] addr, input logic [15:0] data,
                         input int delay);
        wait_req(tag);
        chk({tag, " mem_addr"}, 32'(bus.mem_addr), 32'(addr));
        chk({tag, " pc"}, 32'(bus.pc), 32'(addr));
        for (int i = 0; i < delay; i++) begin
            step();
            chk({tag, " req held"}, 32'(bus.mem_req), 32'd1);
            chk({tag, " addr held"}, 32'(bus.mem_addr), 32'(addr));
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = data;
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'hFFFF;
        chk({tag, " instruction"}, 32'(bus.instruction), 32'(data));
        chk({tag, " inst_load"}, 32'(bus.inst_load), 32'd1);
        chk({tag, " inst_valid"}, 32'(bus.inst_valid), 32'd1);
        chk({tag, " req drop"}, 32'(bus.mem_req), 32'd0);
    endtask

    task automatic command(input string tag, input logic inc, input logic e2, input logic br,
                           input logic [9:0] off, input logic [15:0] exp_addr);
        bus.pc_inc    = inc;
        bus.en_pc_2   = e2;
        bus.branch_en = br;
        bus.pc_offset = off;
        step();
        bus.pc_inc    = 1'b0;
        bus.en_pc_2   = 1'b0;
        bus.branch_en = 1'b0;
        bus.pc_offset = '0;
        chk({tag, " mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, " next addr"}, 32'(bus.mem_addr), 32'(exp_addr));
        chk({tag, " valid clr"}, 32'(bus.inst_valid), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.pc_inc    = 1'b0;
        bus.en_pc_2   = 1'b0;
        bus.branch_en = 1'b0;
        bus.pc_offset = '0;
        repeat (3) step();
        chk("rst mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst pc", 32'(bus.pc), 32'h0000);
        chk("rst instruction", 32'(bus.instruction), 32'h0000);
        chk("rst inst_valid", 32'(bus.inst_valid), 32'd0);
        chk("rst inst_load", 32'(bus.inst_load), 32'd0);

        // Release: one idle cycle, then the first request at the reset vector.
        rst = 1'b0;
        chk("idle mem_req", 32'(bus.mem_req), 32'd0);
        step();
        chk("first req", 32'(bus.mem_req), 32'd1);
        serve("t1", 16'h0000, 16'hA55A, 0);
        step();
        chk("t1 load pulse", 32'(bus.inst_load), 32'd0);
        chk("t1 valid held", 32'(bus.inst_valid), 32'd1);
        chk("t1 instr held", 32'(bus.instruction), 32'hA55A);
        chk("t1 no req", 32'(bus.mem_req), 32'd0);
        step();
        chk("t1 valid held2", 32'(bus.inst_valid), 32'd1);
        command("br 0->10", 1'b1, 1'b0, 1'b1, 10'h007, 16'h0010);

        // Delayed ack: request held stable across all wait cycles.
        serve("t2 delayed", 16'h0010, 16'h1111, 3);
        command("inc2 10->12", 1'b1, 1'b1, 1'b0, 10'h000, 16'h0012);
        serve("t2b", 16'h0012, 16'h2222, 0);
        command("br 12->10", 1'b1, 1'b0, 1'b1, 10'h3FE, 16'h0010);

        serve("t3a", 16'h0010, 16'h3333, 0);
        command("br +5", 1'b1, 1'b0, 1'b1, 10'h005, 16'h001C);
        serve("t3b", 16'h001C, 16'h4444, 1);
        command("br 1c->10", 1'b1, 1'b0, 1'b1, 10'h3F9, 16'h0010);
        serve("t3c", 16'h0010, 16'h5555, 0);
        command("br self", 1'b1, 1'b0, 1'b1, 10'h3FF, 16'h0010);
        serve("t3d", 16'h0010, 16'h6666, 0);
        command("br 10->400", 1'b1, 1'b0, 1'b1, 10'h1F7, 16'h0400);
        serve("t3e", 16'h0400, 16'h7777, 0);
        command("br -512", 1'b1, 1'b0, 1'b1, 10'h200, 16'h0002);

        serve("t4a", 16'h0002, 16'h8888, 0);
        command("br 2->20", 1'b1, 1'b0, 1'b1, 10'h00E, 16'h0020);
        serve("t4b", 16'h0020, 16'h9999, 0);
        command("refetch", 1'b1, 1'b0, 1'b0, 10'h000, 16'h0020);
        // Commands while a fetch is outstanding must not move the PC.
        bus.pc_inc    = 1'b1;
        bus.en_pc_2   = 1'b1;
        bus.branch_en = 1'b1;
        bus.pc_offset = 10'h005;
        step();
        bus.pc_inc    = 1'b0;
        bus.en_pc_2   = 1'b0;
        bus.branch_en = 1'b0;
        bus.pc_offset = '0;
        chk("fetch ign req", 32'(bus.mem_req), 32'd1);
        chk("fetch ign addr", 32'(bus.mem_addr), 32'h0020);
        serve("t4c", 16'h0020, 16'hAAAA, 0);
        command("br+inc2", 1'b1, 1'b1, 1'b1, 10'h001, 16'h0024);

        serve("t5a", 16'h0024, 16'hBBBB, 0);
        command("br 24->fffe", 1'b1, 1'b0, 1'b1, 10'h3EC, 16'hFFFE);
        serve("t5b", 16'hFFFE, 16'hCCCC, 0);
        command("wrap", 1'b1, 1'b1, 1'b0, 10'h000, 16'h0000);
        serve("t5c", 16'h0000, 16'hDDDD, 0);
        command("inc2 0->2", 1'b1, 1'b1, 1'b0, 10'h000, 16'h0002);

        // Reset while the fetch at 0x0002 is waiting; the late ack is dropped.
        step();
        rst = 1'b1;
        step();
        rst           = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 16'hDEAD;
        chk("t6 req", 32'(bus.mem_req), 32'd0);
        chk("t6 pc", 32'(bus.pc), 32'h0000);
        chk("t6 valid", 32'(bus.inst_valid), 32'd0);
        chk("t6 instr clr", 32'(bus.instruction), 32'h0000);
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        chk("t6 late ack instr", 32'(bus.instruction), 32'h0000);
        chk("t6 late ack load", 32'(bus.inst_load), 32'd0);
        chk("t6 late ack valid", 32'(bus.inst_valid), 32'd0);
        serve("t6 refetch", 16'h0000, 16'h1234, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Responder end of the control unit's PC/instruction interface.
- Owns the program counter and fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Presents each instruction to the control unit and applies the control unit's PC commands (pc_inc, en_pc_2, branch_en, pc_offset) to form the next fetch address.
- Sits between the instruction memory and the control unit.

Parameters:
- PC_W, 16, program counter and memory address width.
- INST_W, 16, instruction width.
- OFFS_W, 10, signed branch word-offset width.
- RESET_VECTOR, 16'h0000, PC value after reset; bit 0 must be 0.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- mem_req  out  1  instruction read request.
- mem_addr  out  PC_W  read address; equals pc.
- mem_ack  in  1  one-cycle read completion; mem_rdata valid in the same cycle.
- mem_rdata  in  INST_W  read data.
- instruction  out  INST_W  latched instruction to the control unit.
- inst_valid  out  1  instruction is held and awaiting a PC command.
- inst_load  out  1  one-cycle pulse in the first cycle a new instruction is visible.
- pc  out  PC_W  address of the current instruction.
- pc_inc  in  1  control unit: load next PC.
- en_pc_2  in  1  next PC = pc+2.
- branch_en  in  1  next PC = branch target.
- pc_offset  in  OFFS_W  signed word offset.

Behaviour:
- Single clock. Reset is synchronous and active-high. One always block holds state, pc and instruction.
- Reset values: state S_IDLE, pc=RESET_VECTOR, instruction=0, mem_req=0, inst_valid=0, inst_load=0.
- A reset in any state, including mid-fetch, abandons the request. A late mem_ack arriving in S_IDLE is ignored.
- States:
  - S_IDLE: outputs inactive. Goes to S_FETCH next cycle.
  - S_FETCH: mem_req=1, mem_addr=pc, held stable until mem_ack. On mem_ack: instruction<=mem_rdata, go to S_HOLD. Zero-wait ack (ack in the first request cycle) is legal.
  - S_HOLD: inst_valid=1, mem_req=0. inst_load=1 only in the first S_HOLD cycle. On pc_inc: pc<=next_pc, go to S_FETCH.
- next_pc priority:
  - branch_en=1: pc + 2 + (sign_extend(pc_offset) << 1). branch_en wins over en_pc_2.
  - else en_pc_2=1: pc + 2.
  - else: pc unchanged, so the same address is re-fetched.
- All PC arithmetic is modulo 2^PC_W. pc bit 0 is always forced to 0.
- pc_inc, en_pc_2 and branch_en are ignored outside S_HOLD. mem_ack is ignored outside S_FETCH.
- Throughput: minimum 2 cycles per instruction (1 S_FETCH + 1 S_HOLD).
- Latency: mem_req rises 1 cycle after the pc_inc cycle. instruction/inst_load appear 1 cycle after the mem_ack cycle.
- mem_req, mem_addr, inst_valid, inst_load and instruction are registered or pure state decodes. No combinational path from inputs to outputs.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum S_IDLE=2'd0, S_FETCH=2'd1, S_HOLD=2'd2.
  - PC_W, INST_W, OFFS_W defaults.
  - PC step constant 2.
- Sub-module pc_next_gen: combinational. Inputs pc, en_pc_2, branch_en, pc_offset; output next_pc.

Test Plan:
1. Reset, then mem_ack in the first request cycle with rdata=16'hA55A:
   - required: mem_req high with mem_addr=16'h0000 in cycle 2 after rst falls;
   - instruction=16'hA55A, inst_load pulse 1 cycle, inst_valid held until pc_inc.
2. pc=16'h0010, pc_inc+en_pc_2:
   - required: next mem_addr=16'h0012.
   - Same start with ack delayed 3 cycles: mem_req and mem_addr stable for all 4 cycles.
3. pc=16'h0010, pc_inc+branch_en, pc_offset=10'h005:
   - required: mem_addr=16'h001C.
   - pc_offset=10'h3FF: mem_addr=16'h0010 (jump-to-self).
   - pc_offset=10'h200 from pc=16'h0400: mem_addr=16'h0002.
4. Command edge cases:
   - branch_en and en_pc_2 together (offset 10'h001, pc=16'h0020) -> 16'h0024.
   - pc_inc alone -> re-fetch 16'h0020.
   - pc_inc during S_FETCH -> ignored.
5. Wrap: pc=16'hFFFE with en_pc_2 -> 16'h0000.
6. rst asserted while S_FETCH is waiting:
   - required: next cycle mem_req=0, pc=RESET_VECTOR, inst_valid=0;
   - an ack arriving 1 cycle later does not change instruction.
